bip2_multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the BIP-2 accumulator datapath. Fetches 16-bit instructions
//  (5-bit opcode, 11-bit operand) over a req/valid instruction-memory handshake and keeps the PC.

---
 rtl/bip2_multicycle_control.sv | 97 +++++++++
 tb/tb_bip2_multicycle_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bip2_multicycle_control.sv
// bip2_multicycle_control: BIP-2 fetch/decode/execute sequencer (imem req/valid fetch, PC/IR, datapath selects, ALU op, ACC/RAM strobes, Z/N branches, halt)
module bip2_multicycle_control #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  output logic              Im_req_o,
  input  logic              Im_valid_i,
  output logic [ADDR_W-1:0] ADDR_im_o,
  input  logic [DATA_W-1:0] DATA_im_i,
  output logic [ADDR_W-1:0] DATA_im_o,
  input  logic              z_i,
  input  logic              n_i,
  output logic              SellA_o,
  output logic              SellB_o,
  output logic              Op_o,
  output logic              WrAcc_o,
  output logic              WrRam_o,
  output logic              Halted_o
);
  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(5'h00);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(5'h01);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'h02);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'h03);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'h04);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'h05);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'h06);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(5'h07);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(5'h08);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(5'h09);
  localparam logic [OPC_W-1:0] OP_BGT  = OPC_W'(5'h0A);
  localparam logic [OPC_W-1:0] OP_BGE  = OPC_W'(5'h0B);
  localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(5'h0C);
  localparam logic [OPC_W-1:0] OP_BLE  = OPC_W'(5'h0D);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(5'h0E);
  typedef enum logic [2:0] {FETCH, DECODE, MEMRD, EXEC, HALT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] opd;
  logic is_mem, is_alu, is_imm, is_sub, is_ld, taken, act, sel_ok, in_exec;
  assign opc = ir[DATA_W-1 -: OPC_W];
  assign opd = ir[ADDR_W-1:0];
  always_comb begin
    is_mem = (opc == OP_LD) || (opc == OP_ADD) || (opc == OP_SUB);
    is_alu = (opc == OP_ADD) || (opc == OP_ADDI) || (opc == OP_SUB) || (opc == OP_SUBI);
    is_imm = (opc == OP_LDI) || (opc == OP_ADDI) || (opc == OP_SUBI);
    is_sub = (opc == OP_SUB) || (opc == OP_SUBI);
    is_ld  = (opc == OP_LD) || (opc == OP_LDI);
    taken  = (opc == OP_BEQ) ? z_i :
             (opc == OP_BNE) ? !z_i :
             (opc == OP_BGT) ? (!z_i && !n_i) :
             (opc == OP_BGE) ? !n_i :
             (opc == OP_BLT) ? n_i :
             (opc == OP_BLE) ? (z_i || n_i) :
             (opc == OP_JMP);
  end
  always_ff @(posedge Clock_i) begin
    if (Reset_i) state <= FETCH;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == FETCH)  ? (Im_valid_i ? DECODE : FETCH) :
               (state == DECODE) ? ((opc == OP_HLT) ? HALT : is_mem ? MEMRD : EXEC) :
               (state == MEMRD)  ? EXEC :
               (state == EXEC)   ? FETCH : HALT;
  end
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      pc <= '0;
      ir <= '0;
    end else if (state == FETCH && Im_valid_i) begin
      ir <= DATA_im_i;
      pc <= pc + ADDR_W'(1);
    end else if (state == EXEC && taken) begin
      pc <= opd;
    end
  end
  // Outputs are forced low while Reset_i is high so a strobe due in that cycle never reaches the datapath.
  always_comb begin
    act       = !Reset_i;
    sel_ok    = act && (state == MEMRD || state == EXEC);
    in_exec   = act && (state == EXEC);
    Im_req_o  = act && (state == FETCH);
    ADDR_im_o = act ? pc : '0;
    DATA_im_o = act ? opd : '0;
    SellA_o   = sel_ok && is_alu;
    SellB_o   = sel_ok && is_imm;
    Op_o      = sel_ok && is_sub;
    WrAcc_o   = in_exec && (is_ld || is_alu);
    WrRam_o   = in_exec && (opc == OP_STO);
    Halted_o  = act && (state == HALT);
  end
endmodule

// File: tb/tb_bip2_multicycle_control.sv
// tb_bip2_multicycle_control: randomized instruction stream against an instruction-level reference model
module tb_bip2_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic z = 1'b0;
  logic n = 1'b0;
  logic [15:0] din = '0;
  logic req, sa, sb, op, wa, wr, halt;
  logic [10:0] addr, dout;
  logic [10:0] mpc;
  int tests = 0;
  int fails = 0;
  bip2_multicycle_control dut (
    .Clock_i(clk), .Reset_i(rst), .Im_req_o(req), .Im_valid_i(valid),
    .ADDR_im_o(addr), .DATA_im_i(din), .DATA_im_o(dout), .z_i(z), .n_i(n),
    .SellA_o(sa), .SellB_o(sb), .Op_o(op), .WrAcc_o(wa), .WrRam_o(wr), .Halted_o(halt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    valid = 1'b0;
    tick;
    tick;
    check("reset_outputs", 32'({req, addr, dout, sa, sb, op, wa, wr, halt}), 32'd0);
    rst = 1'b0;
    mpc = '0;
    #1;
    check("reset_release_req", 32'(req), 32'd1);
    check("reset_release_addr", 32'(addr), 32'd0);
  endtask
  // Executes one instruction through the DUT and compares against the architectural model.
  task automatic do_instr(input logic [15:0] w, input logic zf, input logic nf, input int waits);
    logic [4:0] opc;
    logic [10:0] opd;
    logic mem, alu, imm, sub, ld, tk;
    int exp_cyc, cnt, wa_n, wr_n;
    logic [2:0] sel;
    logic [10:0] dout_x;
    opc = w[15:11];
    opd = w[10:0];
    mem = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
    alu = (opc >= 5'd4) && (opc <= 5'd7);
    imm = (opc == 5'd3) || (opc == 5'd5) || (opc == 5'd7);
    sub = (opc == 5'd6) || (opc == 5'd7);
    ld  = (opc == 5'd2) || (opc == 5'd3);
    case (opc)
      5'h08: tk = zf;
      5'h09: tk = !zf;
      5'h0A: tk = !zf && !nf;
      5'h0B: tk = !nf;
      5'h0C: tk = nf;
      5'h0D: tk = zf || nf;
      5'h0E: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    exp_cyc = (opc == 5'd0) ? 1 : mem ? 3 : 2;
    z = zf;
    n = nf;
    check("fetch_req", 32'(req), 32'd1);
    check("fetch_addr", 32'(addr), 32'(mpc));
    for (int i = 0; i < waits; i++) begin
      valid = 1'b0;
      din = 16'($urandom);
      tick;
      check("wait_hold", 32'({req, addr, wa, wr}), 32'({1'b1, mpc, 2'b00}));
    end
    valid = 1'b1;
    din = w;
    tick;
    cnt = 0;
    wa_n = 0;
    wr_n = 0;
    sel = '0;
    dout_x = '0;
    while (!req && !halt && cnt < 10) begin
      valid = 1'($urandom);
      din = 16'($urandom);
      if (wa) wa_n++;
      if (wr) wr_n++;
      if (cnt == exp_cyc - 1) begin
        sel = {sa, sb, op};
        dout_x = dout;
      end
      tick;
      cnt++;
    end
    valid = 1'b0;
    check("cycles", 32'(cnt), 32'(exp_cyc));
    if (opc == 5'd0) begin
      int bad;
      bad = 0;
      check("halt_enter", 32'(halt), 32'd1);
      for (int i = 0; i < 12; i++) begin
        valid = 1'($urandom);
        if ({halt, req, wa, wr} !== 4'b1000) bad++;
        tick;
      end
      valid = 1'b0;
      check("halt_absorbing", 32'(bad), 32'd0);
      do_reset;
    end else begin
      check("wracc_pulses", 32'(wa_n), 32'(alu || ld));
      check("wrram_pulses", 32'(wr_n), 32'(opc == 5'd1));
      check("exec_sel", 32'(sel), 32'({alu, imm, sub}));
      check("exec_operand", 32'(dout_x), 32'(opd));
      mpc = tk ? opd : mpc + 11'd1;
      check("next_pc", 32'(addr), 32'(mpc));
    end
  endtask
  initial begin
    mpc = '0;
    do_reset;
    do_instr(16'h1802, 1'b0, 1'b0, 0);
    do_instr(16'h3801, 1'b0, 1'b0, 0);
    do_instr(16'h47FF, 1'b1, 1'b0, 0);
    do_instr(16'h1805, 1'b0, 1'b0, 3);
    do_instr(16'h4923, 1'b1, 1'b0, 0);
    do_instr(16'h6855, 1'b0, 1'b1, 1);
    do_instr(16'h5077, 1'b0, 1'b1, 0);
    do_instr(16'h2010, 1'b0, 1'b0, 0);
    do_instr(16'h0810, 1'b0, 1'b0, 2);
    do_instr(16'h0000, 1'b0, 1'b0, 0);
    for (int k = 0; k < 250; k++) begin
      logic [4:0] o;
      o = 5'($urandom_range(0, 31));
      if (o == 5'd0 && $urandom_range(0, 3) != 0) o = 5'h0E;
      do_instr({o, 11'($urandom)}, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
    do_reset;
    valid = 1'b1;
    din = 16'h1055;
    tick;
    valid = 1'b0;
    tick;
    tick;
    check("ld_exec_wracc", 32'(wa), 32'd1);
    rst = 1'b1;
    #1;
    check("reset_kills_wracc", 32'({wa, wr, req}), 32'd0);
    tick;
    rst = 1'b0;
    mpc = '0;
    #1;
    check("post_reset_fetch", 32'({req, addr}), 32'({1'b1, 11'd0}));
    do_instr(16'h1C01, 1'b0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
